// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, port
// identifiers, lock-state encoding and the statistics counter helper.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int STAT_W     = 16;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK_P0  = 2'd1,
    LOCK_P1  = 2'd2
  } lock_state_t;

  // Statistics counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (value == {STAT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin picker. Only eligible requesters compete; on a tie the
// port that was not granted last time wins. Purely combinational.
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] elig,
  input  logic       rr_last,
  output logic [1:0] gnt
);

  logic [1:0] cand;

  // Mask requests by eligibility, then break a tie against the last winner.
  always_comb begin
    cand = req & elig;
    gnt  = cand;
    if (cand == 2'b11) begin
      gnt = (rr_last == PORT1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single data_mem port between the processor
// (port 0) and the debug/loader (port 1). Grant is combinational, the chosen
// transfer is registered onto the memory strobes one cycle later, and read
// data is routed back to its owner the cycle after that.
// Optional statistics counters are built when DMEM_ARBITER_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_rd_enb,
  output logic              mem_wr_enb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [STAT_W-1:0] stat_p0_cnt,
  output logic [STAT_W-1:0] stat_p1_cnt,
  output logic [STAT_W-1:0] stat_conflict_cnt
);

  lock_state_t       lock_state, lock_next;
  logic              rr_last, rr_next;
  logic              locked_now;
  logic [1:0]        elig;
  logic [1:0]        pick;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              iss_rd, iss_tag;
  logic              rsp_rd, rsp_tag;

  // A held lock restricts eligibility to its owner; dropping the owner's lock
  // line opens both ports in that very cycle.
  always_comb begin
    elig       = 2'b11;
    locked_now = 1'b0;
    case (lock_state)
      LOCK_P0: if (p0_lock) begin
        elig       = 2'b01;
        locked_now = 1'b1;
      end
      LOCK_P1: if (p1_lock) begin
        elig       = 2'b10;
        locked_now = 1'b1;
      end
      default: ;
    endcase
  end

  dmem_arb_rr u_rr (
    .req     ({p1_req, p0_req}),
    .elig    (elig),
    .rr_last (rr_last),
    .gnt     (pick)
  );

  assign gnt     = pick & {2{~reset}};
  assign any_gnt = |gnt;
  assign p0_gnt  = gnt[0];
  assign p1_gnt  = gnt[1];

  // Next lock state and round-robin pointer: while the lock is held nothing
  // moves; otherwise the winner becomes rr_last and may take the lock.
  always_comb begin
    lock_next = lock_state;
    rr_next   = rr_last;
    if (!locked_now) begin
      lock_next = UNLOCKED;
      if (gnt[0]) begin
        rr_next = PORT0;
        if (p0_lock) lock_next = LOCK_P0;
      end else if (gnt[1]) begin
        rr_next = PORT1;
        if (p1_lock) lock_next = LOCK_P1;
      end
    end
  end

  // Lock FSM and round-robin pointer registers; port 0 wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_state <= UNLOCKED;
      rr_last    <= PORT1;
    end else begin
      lock_state <= lock_next;
      rr_last    <= rr_next;
    end
  end

  // Select the request fields of whichever port won this cycle.
  always_comb begin
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (gnt[1]) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  // Issue stage: drive data_mem with the granted transfer and remember who
  // owns it and whether a read response is due.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_rd_enb  <= 1'b0;
      mem_wr_enb  <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      iss_rd      <= 1'b0;
      iss_tag     <= PORT0;
    end else begin
      mem_rd_enb <= any_gnt & ~sel_we;
      mem_wr_enb <= any_gnt & sel_we;
      iss_rd     <= any_gnt & ~sel_we;
      iss_tag    <= gnt[1];
      if (any_gnt) begin
        mem_addr    <= sel_addr;
        mem_wr_data <= sel_wdata;
      end
    end
  end

  // Response stage: aligns owner tag and read flag with data_mem's read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_rd  <= 1'b0;
      rsp_tag <= PORT0;
    end else begin
      rsp_rd  <= iss_rd;
      rsp_tag <= iss_tag;
    end
  end

  assign p0_rvalid = rsp_rd & (rsp_tag == PORT0);
  assign p1_rvalid = rsp_rd & (rsp_tag == PORT1);
  assign p0_rdata  = p0_rvalid ? mem_rd_data : '0;
  assign p1_rdata  = p1_rvalid ? mem_rd_data : '0;

`ifdef DMEM_ARBITER_STATS_EN
  logic [STAT_W-1:0] cnt_p0, cnt_p1, cnt_conflict;

  // Saturating grant and conflict counters; with a single grant per cycle,
  // both ports requesting always means one of them was turned away.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_p0       <= '0;
      cnt_p1       <= '0;
      cnt_conflict <= '0;
    end else begin
      if (gnt[0]) cnt_p0 <= sat_inc(cnt_p0);
      if (gnt[1]) cnt_p1 <= sat_inc(cnt_p1);
      if (p0_req && p1_req) cnt_conflict <= sat_inc(cnt_conflict);
    end
  end

  assign stat_p0_cnt       = cnt_p0;
  assign stat_p1_cnt       = cnt_p1;
  assign stat_conflict_cnt = cnt_conflict;
`else
  assign stat_p0_cnt       = '0;
  assign stat_p1_cnt       = '0;
  assign stat_conflict_cnt = '0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port between two requesters: port 0 (processor load/store) and port 1 (debug/loader).
- Sits between the requesters and data_mem in the cpu top level.
- Provides round-robin arbitration, an optional ownership lock for atomic sequences, a registered issue stage to the memory, and return of read data routed to the owner.
- Fixed latency: handshake in cycle N, memory strobe in N+1, read data valid in N+2. Back-to-back transactions are pipelined, one per cycle.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data width (matches reg_8b datapath)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-high
p0_req  in  1  port 0 request; held until granted
p0_we  in  1  port 0 write (1) / read (0)
p0_lock  in  1  port 0 requests/holds ownership lock
p0_addr  in  ADDR_W  port 0 address
p0_wdata  in  DATA_W  port 0 write data
p0_gnt  out  1  port 0 handshake accepted this cycle (combinational)
p0_rvalid  out  1  port 0 read data valid
p0_rdata  out  DATA_W  port 0 read data
p1_req, p1_we, p1_lock, p1_addr, p1_wdata  in  as port 0  port 1 request side
p1_gnt, p1_rvalid, p1_rdata  out  as port 0  port 1 response side
mem_rd_enb  out  1  data_mem read strobe (registered)
mem_wr_enb  out  1  data_mem write strobe (registered)
mem_addr  out  ADDR_W  data_mem address (registered)
mem_wr_data  out  DATA_W  data_mem write data (registered)
mem_rd_data  in  DATA_W  data_mem read data, valid one cycle after mem_rd_enb
stat_p0_cnt, stat_p1_cnt, stat_conflict_cnt  out  16 each  statistics (see Optional Feature)

Behaviour:
- Reset (async, active-high): all outputs 0, rr_last=1 (port 0 wins the first conflict), lock state UNLOCKED, pipeline empty.
- Handshake: transfer occurs when pX_req and pX_gnt are both high in the same cycle. A requester keeps its request fields stable until granted. At most one gnt per cycle.
- Grant, lock state UNLOCKED:
  - Single requester: granted.
  - Both requesting: grant the port != rr_last.
  - rr_last updates to the granted port on every grant.
- Lock FSM states: UNLOCKED, LOCK_P0, LOCK_P1.
  - UNLOCKED -> LOCK_Px when port x is granted with pX_lock=1.
  - LOCK_Px: only port x is eligible; the other port's gnt is forced to 0.
  - LOCK_Px -> UNLOCKED on the first cycle pX_lock=0, evaluated combinationally that same cycle. The other port becomes eligible that cycle.
  - Granted transfers do not change rr_last while in LOCK_Px.
- Issue stage (N+1): the granted transfer's we, addr and wdata are registered onto the mem_* outputs.
  - mem_rd_enb = !we, mem_wr_enb = we. Both are 0 in cycles with no grant.
  - A 1-bit owner tag and a read flag are also registered.
- Response stage (N+2): tag/flag registered again. If the flag is set, pOwner_rvalid=1 and pOwner_rdata=mem_rd_data (pass-through). The non-owner rdata is 0.
- Writes produce no response.
- Sustained throughput: 1 transaction/cycle.
- Simultaneous read grant at N and write grant at N+1 to the same address: ordering is issue order, so the read returns the old value.
- Reset mid-operation: in-flight transfers are dropped, no rvalid is generated, lock is released.
- pX_lock without pX_req while UNLOCKED: ignored.

Optional Feature:
- Macro: DMEM_ARBITER_STATS_EN.
- Defined:
  - stat_p0_cnt and stat_p1_cnt count grants per port.
  - stat_conflict_cnt counts cycles where both req are high and one port is denied.
  - All three are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: the three stat ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- Package dmem_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - Port-ID constants PORT0=1'b0, PORT1=1'b1.
  - Lock-state encoding UNLOCKED=2'd0, LOCK_P0=2'd1, LOCK_P1=2'd2.
  - STAT_W=16.
- One sub-module, dmem_arb_rr: 2-way round-robin picker with eligibility masks. Inputs req[1:0], elig[1:0], rr_last; outputs gnt[1:0]. Purely combinational.
- The rr_last flop and the lock FSM stay in dmem_arbiter.

Test Plan:
1. Reset then p0 read of addr 8'h10, mem holds 8'hA5 -> p0_gnt same cycle; mem_rd_enb=1, mem_addr=8'h10 next cycle; p0_rvalid=1, p0_rdata=8'hA5 the cycle after; p1 outputs stay 0.
2. Both ports request reads continuously for 4 cycles -> grants alternate p0,p1,p0,p1; four rvalids arrive 2 cycles later in the same order; stat_conflict_cnt=4 with the macro defined.
3. p1 writes 8'h3C to 8'h20 with p1_lock=1 for 3 transfers while p0_req=1 -> p0_gnt=0 for all 3. When p1_lock drops, p0 is granted that cycle and reads back 8'h3C.
4. Read of 8'h30 (old 8'h11) granted at N, write 8'h22 to 8'h30 granted at N+1 -> read returns 8'h11; a later read returns 8'h22.
5. Assert reset in the cycle between mem_rd_enb and the expected rvalid -> no rvalid; all outputs 0 immediately; the next conflict is granted to p0.
6. With the macro defined, force 65540 p0 grants -> stat_p0_cnt saturates at 16'hFFFF. Without the macro, all stat ports stay 0.
